ob_mk_qry_ctrl: RTL
===================

# ob_mk_qry_ctrl

Market-order qualification controller sitting directly upstream of the table quantity-count unit. It accepts one market-order query at a time over a valid/ready handshake and launches a single-cycle count command. It waits for the count unit to finish, then compares the requested quantity against the accumulated table quantity. It returns a registered fill decision over a valid/ready handshake, with a watchdog that terminates a stalled count.

## Interface
- `QTY_W`, 16: width of a table/requested quantity.
- `ACC_W`, 20: width of the accumulated quantity returned by the count unit.
- `ID_W`, 8: width of the order identifier.
- `TIMEOUT_N`, 64: maximum WAIT-state cycles before a timeout response; legal range 2..65535.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state while low.
- `in_vld`  in  1  query valid.
- `in_id`  in  ID_W  query identifier.
- `in_qty`  in  QTY_W  requested quantity.
- `in_rdy`  out  1  query accepted when `in_vld & in_rdy`.
- `cnt_cmd_vld`  out  1  registered, one-cycle pulse to the count unit.
- `cnt_busy`  in  1  count unit busy, combinational from its next state.
- `cnt_quantity`  in  ACC_W  accumulated quantity; valid in the cycle `cnt_busy` falls.
- `out_vld`  out  1  response valid.
- `out_rdy`  in  1  response consumed when `out_vld & out_rdy`.
- `out_id`  out  ID_W  echoed identifier.
- `out_fill`  out  1  request fully fillable (`in_qty <= available`).
- `out_fill_qty`  out  QTY_W  min(requested, available).
- `out_avail`  out  ACC_W  captured available quantity.
- `out_err`  out  1  count timed out; `out_fill`, `out_fill_qty`, and `out_avail` are 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: `in_rdy` 1 (subject to `cnt_busy`). All other outputs, the timer, and the captured id/qty are 0.
- IDLE:
  - `in_rdy = ~cnt_busy`.
  - On handshake, capture `in_id` and `in_qty`.
  - If `in_qty == 0`, go to RESP with `out_fill=1`, `out_fill_qty=0`, `out_avail=0`, `out_err=0`. No command is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - `cnt_cmd_vld=1` for exactly this cycle.
  - Clear the timer.
  - Go to WAIT unconditionally.
- WAIT:
  - If `~cnt_busy`: capture `cnt_quantity` into `out_avail`. Set `out_fill = (zero-extended qty <= avail)`. Set `out_fill_qty = out_fill ? qty : avail[QTY_W-1:0]`. Set `out_err=0`. Go to RESP.
  - Else if timer `== TIMEOUT_N-1`: set `out_err=1`, all data fields 0, go to RESP.
  - Else increment the timer.
- RESP:
  - `out_vld=1`. All `out_*` fields are held stable until `out_rdy`.
  - On handshake, deassert `out_vld` and return to IDLE.
- `in_rdy` is 0 in every state except IDLE.
- Comparison is done at ACC_W width. `out_fill_qty` can never exceed `in_qty`, so no truncation loss occurs.
- After a timeout the count unit may still be busy. IDLE gating on `cnt_busy` blocks the next command until it drains.
- Reset asserted mid-operation: return to IDLE immediately and drop `out_vld`. Any in-flight count is abandoned; the `cnt_busy` gating handles it.

## Timing
- All outputs except `in_rdy` are registered. `in_rdy` is combinational from state and `cnt_busy`.
- Latency with the count unit taking R accumulate rounds:
  - Accept at cycle T0.
  - `cnt_cmd_vld` at T0+1.
  - `cnt_busy` low at T0+R+4, where capture occurs.
  - `out_vld` at T0+R+5.
- Example: N=16 table, R=3 gives `out_vld` at T0+8.
- Zero-quantity query: `out_vld` at T0+1.
- Timeout: `out_vld` at T0+TIMEOUT_N+2.
- Back-to-back throughput: one query per (latency + 1) cycles with `out_rdy` held high. A response handshake and a new query handshake never occur in the same cycle.

## Test plan
- Basic fill:
  - Stimulus: `in_qty=100`, id=0x12; count model returns 250 after R=3.
  - Required: `out_vld` at T0+8 with `out_fill=1`, `out_fill_qty=100`, `out_avail=250`, `out_err=0`, `out_id=0x12`; `cnt_cmd_vld` is a single pulse at T0+1.
- Partial fill:
  - Stimulus: `in_qty=300`, count returns 250.
  - Required: `out_fill=0`, `out_fill_qty=250`, `out_avail=250`.
- Zero quantity:
  - Stimulus: `in_qty=0`.
  - Required: `cnt_cmd_vld` never asserts; `out_vld` at T0+1 with `out_fill=1`, `out_fill_qty=0`.
- Timeout:
  - Stimulus: `TIMEOUT_N=8`, count model holds `cnt_busy=1`.
  - Required: `out_vld` at T0+10 with `out_err=1` and all data 0; `in_rdy` stays 0 until `cnt_busy` drops.
- Backpressure:
  - Stimulus: `out_rdy=0` for 5 cycles after `out_vld`, with `in_vld` held high with a second query.
  - Required: outputs stable throughout and `in_rdy=0`; the second query is accepted the cycle after the response handshake.
- Async reset mid-WAIT:
  - Stimulus: drive `rst=0` mid-WAIT.
  - Required: `out_vld=0` and `cnt_cmd_vld=0` immediately. After release, `in_rdy` follows `~cnt_busy` and the next query completes normally.

Source files
------------

// File: rtl/ob_mk_qry_ctrl_if.sv
// Query / count-unit / response bundle for the market-order qualification controller.
//   slave  : controller side (accepts queries, drives count command, returns responses)
//   master : environment side (issues queries, models the count unit, consumes responses)
interface ob_mk_qry_ctrl_if #(
    parameter int unsigned QTY_W = 16,
    parameter int unsigned ACC_W = 20,
    parameter int unsigned ID_W  = 8
);
    // query channel
    logic             in_vld;
    logic [ID_W-1:0]  in_id;
    logic [QTY_W-1:0] in_qty;
    logic             in_rdy;

    // count unit
    logic             cnt_cmd_vld;
    logic             cnt_busy;
    logic [ACC_W-1:0] cnt_quantity;

    // response channel
    logic             out_vld;
    logic             out_rdy;
    logic [ID_W-1:0]  out_id;
    logic             out_fill;
    logic [QTY_W-1:0] out_fill_qty;
    logic [ACC_W-1:0] out_avail;
    logic             out_err;

    modport slave (
        input  in_vld, in_id, in_qty,
        output in_rdy,
        output cnt_cmd_vld,
        input  cnt_busy, cnt_quantity,
        output out_vld,
        input  out_rdy,
        output out_id, out_fill, out_fill_qty, out_avail, out_err
    );

    modport master (
        output in_vld, in_id, in_qty,
        input  in_rdy,
        input  cnt_cmd_vld,
        output cnt_busy, cnt_quantity,
        input  out_vld,
        output out_rdy,
        input  out_id, out_fill, out_fill_qty, out_avail, out_err
    );
endinterface

// File: rtl/ob_mk_qry_ctrl.sv
// Market-order qualification controller.
// Accepts one query at a time, pulses a count command, waits for the count unit
// (with a watchdog), and returns a registered fill decision.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   bus   - ob_mk_qry_ctrl_if.slave: query in, count command/result, response out
module ob_mk_qry_ctrl #(
    parameter int unsigned QTY_W     = 16,
    parameter int unsigned ACC_W     = 20,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned TIMEOUT_N = 64
) (
    input  logic              clk,
    input  logic              rst,
    ob_mk_qry_ctrl_if.slave   bus
);

    localparam int unsigned TMR_W = 16;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [QTY_W-1:0] qty_q, qty_d;
    logic             cmd_q, cmd_d;
    logic             vld_q, vld_d;
    logic             fill_q, fill_d;
    logic [QTY_W-1:0] fill_qty_q, fill_qty_d;
    logic [ACC_W-1:0] avail_q, avail_d;
    logic             err_q, err_d;

    logic             in_rdy_c;
    logic [ACC_W-1:0] qty_ext_c;
    logic             fits_c;

    // New commands are held off while a (possibly abandoned) count is still draining.
    assign in_rdy_c  = (state_q == ST_IDLE) && !bus.cnt_busy;
    assign qty_ext_c = ACC_W'(qty_q);
    assign fits_c    = (qty_ext_c <= bus.cnt_quantity);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        id_d       = id_q;
        qty_d      = qty_q;
        cmd_d      = 1'b0;
        vld_d      = vld_q;
        fill_d     = fill_q;
        fill_qty_d = fill_qty_q;
        avail_d    = avail_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_vld && in_rdy_c) begin
                    id_d  = bus.in_id;
                    qty_d = bus.in_qty;
                    if (bus.in_qty == '0) begin
                        // Nothing to count: trivially fillable
                        vld_d      = 1'b1;
                        fill_d     = 1'b1;
                        fill_qty_d = '0;
                        avail_d    = '0;
                        err_d      = 1'b0;
                        state_d    = ST_RESP;
                    end else begin
                        cmd_d   = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (!bus.cnt_busy) begin
                    avail_d    = bus.cnt_quantity;
                    fill_d     = fits_c;
                    // min(requested, available); available fits QTY_W when not fillable
                    fill_qty_d = fits_c ? qty_q : bus.cnt_quantity[QTY_W-1:0];
                    err_d      = 1'b0;
                    vld_d      = 1'b1;
                    state_d    = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    fill_d     = 1'b0;
                    fill_qty_d = '0;
                    avail_d    = '0;
                    err_d      = 1'b1;
                    vld_d      = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_RESP: begin
                if (bus.out_rdy) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            id_q       <= '0;
            qty_q      <= '0;
            cmd_q      <= 1'b0;
            vld_q      <= 1'b0;
            fill_q     <= 1'b0;
            fill_qty_q <= '0;
            avail_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            id_q       <= id_d;
            qty_q      <= qty_d;
            cmd_q      <= cmd_d;
            vld_q      <= vld_d;
            fill_q     <= fill_d;
            fill_qty_q <= fill_qty_d;
            avail_q    <= avail_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_rdy       = in_rdy_c;
    assign bus.cnt_cmd_vld  = cmd_q;
    assign bus.out_vld      = vld_q;
    assign bus.out_id       = id_q;
    assign bus.out_fill     = fill_q;
    assign bus.out_fill_qty = fill_qty_q;
    assign bus.out_avail    = avail_q;
    assign bus.out_err      = err_q;

endmodule
